// File: rtl/ysyx_24080006_pkg.sv
// Shared types and constants for the ysyx_24080006 execute-stage core.
package ysyx_24080006_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_SLL   = 4'h2,
        ALU_SRL   = 4'h3,
        ALU_SRA   = 4'h4,
        ALU_SLT   = 4'h5,
        ALU_SLTU  = 4'h6,
        ALU_XOR   = 4'h7,
        ALU_OR    = 4'h8,
        ALU_AND   = 4'h9,
        ALU_PASSB = 4'hA,
        ALU_EQ    = 4'hB,
        ALU_NE    = 4'hC,
        ALU_GE    = 4'hD,
        ALU_GEU   = 4'hE
    } alu_op_e;

    // Branch LT/LTU produce exactly the SLT/SLTU result, so they share encodings; 4'hF is undefined.
    localparam alu_op_e ALU_LT  = ALU_SLT;
    localparam alu_op_e ALU_LTU = ALU_SLTU;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [31:0] MVENDORID     = 32'h7973_7978;
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ysyx_24080006_exu_core_mdu.sv
// Iterative RV32M unit: 32-step shift-add multiplier and restoring divider on magnitudes.
// MDU_FAST_MUL_EN selects a single-cycle combinational multiply instead of the shift-add loop.
module ysyx_24080006_mdu_iter
    import ysyx_24080006_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        valid_o,
    output logic [31:0] result_o
);

    mdu_state_e  state_q, state_d;
    mdu_op_e     op_q, op_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
    logic        neg_q, neg_d, rneg_q, rneg_d;
    logic [4:0]  cnt_q, cnt_d;

    mdu_op_e     op_start;
    logic        is_div, a_signed, b_signed, sa, sb, start_short;
    logic [32:0] mul_sum, div_sh;
    logic [31:0] div_diff, hi_n, lo_n, mul_res, div_res;
    logic [63:0] prod;

    assign op_start = mdu_op_e'(op_i);
    assign is_div   = op_i[2];
    assign a_signed = (op_start == MDU_MUL) || (op_start == MDU_MULH) ||
                      (op_start == MDU_MULHSU) || (op_start == MDU_DIV) || (op_start == MDU_REM);
    assign b_signed = (op_start == MDU_MUL) || (op_start == MDU_MULH) ||
                      (op_start == MDU_DIV) || (op_start == MDU_REM);
    assign sa       = a_signed & a_i[31];
    assign sb       = b_signed & b_i[31];

`ifdef MDU_FAST_MUL_EN
    logic signed [32:0] fa, fb;
    logic signed [63:0] fast_prod;
    assign fa          = {sa, a_i};
    assign fb          = {sb, b_i};
    assign fast_prod   = 64'(fa) * 64'(fb);
    assign start_short = !is_div || (b_i == 32'd0);
`else
    assign start_short = is_div && (b_i == 32'd0);
`endif

    // One iteration step; the multiplier lives in lo_q, the dividend shifts out of lo_q.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    assign div_sh   = {hi_q, lo_q[31]};
    assign div_diff = div_sh[31:0] - b_q;

    always_comb begin
        if (op_q[2]) begin
            if (div_sh >= {1'b0, b_q}) begin
                hi_n = div_diff;
                lo_n = {lo_q[30:0], 1'b1};
            end else begin
                hi_n = div_sh[31:0];
                lo_n = {lo_q[30:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[32:1];
            lo_n = {mul_sum[0], lo_q[31:1]};
        end
    end

    assign prod    = neg_q ? (~{hi_n, lo_n} + 64'd1) : {hi_n, lo_n};
    assign mul_res = (op_q == MDU_MUL) ? prod[31:0] : prod[63:32];
    assign div_res = op_q[1] ? mag(hi_n, rneg_q) : mag(lo_n, neg_q);

    // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state_q <= MDU_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal gets a value before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (valid_i) state_d = start_short ? MDU_DONE : MDU_BUSY;
            MDU_BUSY: begin
                if (!valid_i)            state_d = MDU_IDLE;
                else if (cnt_q == 5'd31) state_d = MDU_DONE;
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    always_comb begin
        valid_o = (state_q == MDU_DONE);
    end

    always_comb begin
        op_d   = op_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        case (state_q)
            MDU_IDLE: if (valid_i) begin
                op_d   = op_start;
                hi_d   = 32'd0;
                lo_d   = mag(a_i, sa);
                b_d    = mag(b_i, sb);
                neg_d  = sa ^ sb;
                rneg_d = sa;
                cnt_d  = 5'd0;
                if (is_div && (b_i == 32'd0)) res_d = op_i[1] ? a_i : 32'hFFFF_FFFF;
`ifdef MDU_FAST_MUL_EN
                if (!is_div) res_d = (op_start == MDU_MUL) ? fast_prod[31:0] : fast_prod[63:32];
`endif
            end
            MDU_BUSY: if (valid_i) begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) res_d = op_q[2] ? div_res : mul_res;
            end
            default: ;
        endcase
    end

    // NOTE: working registers are always loaded at start before use, so only res_q needs reset.
    always_ff @(posedge clock) begin
        if (reset) res_q <= 32'd0;
        else       res_q <= res_d;
    end

    always_ff @(posedge clock) begin
        op_q   <= op_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        b_q    <= b_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
        cnt_q  <= cnt_d;
    end

    assign result_o = res_q;

endmodule

// File: rtl/ysyx_24080006_exu_core.sv
// EX-stage compute core: combinational ALU, machine CSR file and the iterative MDU.
// Build option: MDU_FAST_MUL_EN (single-cycle multiply inside the MDU).
module ysyx_24080006_exu_core
    import ysyx_24080006_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter logic [31:0] MARCHID = 32'h016F_6E86
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_c,
    input  logic            mdu_valid_i,
    input  logic [2:0]      mdu_op,
    output logic            mdu_valid_o,
    output logic [XLEN-1:0] mdu_c,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            ecall,
    input  logic            mret,
    output logic [XLEN-1:0] csr_rdata
);

    logic [4:0] shamt;
    assign shamt = op_b[4:0];

    always_comb begin
        case (alu_op_e'(alu_op))
            ALU_ADD:   alu_c = op_a + op_b;
            ALU_SUB:   alu_c = op_a - op_b;
            ALU_SLL:   alu_c = op_a << shamt;
            ALU_SRL:   alu_c = op_a >> shamt;
            ALU_SRA:   alu_c = $signed(op_a) >>> shamt;
            ALU_SLT:   alu_c = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_c = {31'd0, op_a < op_b};
            ALU_XOR:   alu_c = op_a ^ op_b;
            ALU_OR:    alu_c = op_a | op_b;
            ALU_AND:   alu_c = op_a & op_b;
            ALU_PASSB: alu_c = op_b;
            ALU_EQ:    alu_c = {31'd0, op_a == op_b};
            ALU_NE:    alu_c = {31'd0, op_a != op_b};
            ALU_GE:    alu_c = {31'd0, $signed(op_a) >= $signed(op_b)};
            ALU_GEU:   alu_c = {31'd0, op_a >= op_b};
            default:   alu_c = '0;
        endcase
    end

    logic [31:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [31:0] csr_old, csr_new;
    logic        csr_we;

    always_comb begin
        case (csr_addr)
            CSR_MSTATUS:   csr_old = mstatus_q;
            CSR_MTVEC:     csr_old = mtvec_q;
            CSR_MEPC:      csr_old = mepc_q;
            CSR_MCAUSE:    csr_old = mcause_q;
            CSR_MVENDORID: csr_old = MVENDORID;
            CSR_MARCHID:   csr_old = MARCHID;
            default:       csr_old = 32'd0;
        endcase
    end

    assign csr_rdata = ecall ? mtvec_q : (mret ? mepc_q : csr_old);

    always_comb begin
        case (csr_op_e'(csr_op))
            CSR_RW:  csr_new = csr_wdata;
            CSR_RS:  csr_new = csr_old | csr_wdata;
            CSR_RC:  csr_new = csr_old & ~csr_wdata;
            default: csr_new = csr_old;
        endcase
    end

    // A trap entry outranks any CSR write carried by the same instruction.
    assign csr_we = issue && !ecall && (csr_op_e'(csr_op) != CSR_NONE);

    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (issue && ecall) begin
            mepc_d   = pc;
            mcause_d = CAUSE_ECALL_M;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: mstatus_d = csr_new;
                CSR_MTVEC:   mtvec_d   = csr_new;
                CSR_MEPC:    mepc_d    = csr_new;
                CSR_MCAUSE:  mcause_d  = csr_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus_q <= MSTATUS_RESET;
            mtvec_q   <= 32'd0;
            mepc_q    <= 32'd0;
            mcause_q  <= 32'd0;
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    ysyx_24080006_mdu_iter u_mdu (
        .clock    (clock),
        .reset    (reset),
        .valid_i  (mdu_valid_i),
        .op_i     (mdu_op),
        .a_i      (op_a),
        .b_i      (op_b),
        .valid_o  (mdu_valid_o),
        .result_o (mdu_c)
    );

endmodule

// File: tb/tb_ysyx_24080006_exu_core.sv
// Self-checking bench for ysyx_24080006_exu_core: directed and random ALU, MDU and CSR traffic.
module tb_ysyx_24080006_exu_core;
    import ysyx_24080006_pkg::*;

    logic        clock = 1'b0;
    logic        reset, issue, mdu_valid_i, mdu_valid_o, ecall, mret;
    logic [31:0] pc, op_a, op_b, alu_c, mdu_c, csr_wdata, csr_rdata;
    logic [3:0]  alu_op;
    logic [2:0]  mdu_op;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

    always #5 clock = ~clock;

    ysyx_24080006_exu_core dut (
        .clock       (clock),
        .reset       (reset),
        .issue       (issue),
        .pc          (pc),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_op      (alu_op),
        .alu_c       (alu_c),
        .mdu_valid_i (mdu_valid_i),
        .mdu_op      (mdu_op),
        .mdu_valid_o (mdu_valid_o),
        .mdu_c       (mdu_c),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .csr_wdata   (csr_wdata),
        .ecall       (ecall),
        .mret        (mret),
        .csr_rdata   (csr_rdata)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa = int'(a);
        int sb = int'(b);
        case (alu_op_e'(op))
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_SLL:   return a << b[4:0];
            ALU_SRL:   return a >> b[4:0];
            ALU_SRA:   return 32'(sa >>> b[4:0]);
            ALU_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:   return a ^ b;
            ALU_OR:    return a | b;
            ALU_AND:   return a & b;
            ALU_PASSB: return b;
            ALU_EQ:    return (a == b) ? 32'd1 : 32'd0;
            ALU_NE:    return (a != b) ? 32'd1 : 32'd0;
            ALU_GE:    return (sa >= sb) ? 32'd1 : 32'd0;
            ALU_GEU:   return (a >= b) ? 32'd1 : 32'd0;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = int'(a);
        longint          sb = int'(b);
        longint          ub = {32'd0, b};
        longint          p;
        longint unsigned pu;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (mdu_op_e'(op))
            MDU_MUL:    begin p = sa * sb; return p[31:0];  end
            MDU_MULH:   begin p = sa * sb; return p[63:32]; end
            MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
            MDU_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            MDU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(int'(a) / int'(b));
            MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MDU_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(int'(a) % int'(b));
            default:    return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int mdu_lat(input logic [2:0] op, input logic [31:0] b);
        if (op[2] && (b == 32'd0)) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] csr_ref(input logic [11:0] addr);
        case (addr)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hF11: return 32'h7973_7978;
            12'hF12: return 32'h016F_6E86;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 32'h1800;
        m_mtvec   = 32'd0;
        m_mepc    = 32'd0;
        m_mcause  = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; mdu_valid_i = 1'b0; issue = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_csr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
        logic [31:0] v;
        v = csr_ref(addr);
        case (op)
            2'd1:    v = wd;
            2'd2:    v = v | wd;
            2'd3:    v = v & ~wd;
            default: ;
        endcase
        @(negedge clock);
        csr_addr = addr; csr_op = op; csr_wdata = wd; issue = 1'b1;
        @(negedge clock);
        issue = 1'b0; csr_op = 2'd0;
        case (addr)
            12'h300: m_mstatus = v;
            12'h305: m_mtvec   = v;
            12'h341: m_mepc    = v;
            12'h342: m_mcause  = v;
            default: ;
        endcase
    endtask

    task automatic check_csr(input string tag, input logic [11:0] addr);
        csr_addr = addr;
        #1 check(tag, csr_rdata, csr_ref(addr));
    endtask

    task automatic run_mdu(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expected);
        int lat = 0;
        @(negedge clock);
        mdu_op = op; op_a = a; op_b = b; mdu_valid_i = 1'b1;
        @(posedge clock);
        #1 op_a = $urandom; op_b = $urandom; mdu_op = 3'($urandom_range(0, 7));
        while (lat < 40) begin
            @(negedge clock);
            lat++;
            if (mdu_valid_o) break;
        end
        check({tag, " latency"}, 32'(lat), 32'(mdu_lat(op, b)));
        check({tag, " result"}, mdu_c, expected);
        mdu_valid_i = 1'b0;
        @(negedge clock);
        check({tag, " one-cycle pulse"}, {31'd0, mdu_valid_o}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [11:0] addrs [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h123};
        reset = 1'b1; issue = 1'b0; pc = '0; op_a = '0; op_b = '0; alu_op = '0;
        mdu_valid_i = 1'b0; mdu_op = '0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
        ecall = 1'b0; mret = 1'b0;
        do_reset();

        // Reset state
        #1 check("reset mdu_valid_o", {31'd0, mdu_valid_o}, 32'd0);
        check("reset mdu_c", mdu_c, 32'd0);
        csr_addr = 12'h300; #1 check("reset mstatus", csr_rdata, 32'h1800);
        csr_addr = 12'h305; #1 check("reset mtvec", csr_rdata, 32'd0);
        csr_addr = 12'h341; #1 check("reset mepc", csr_rdata, 32'd0);
        csr_addr = 12'h342; #1 check("reset mcause", csr_rdata, 32'd0);
        csr_addr = 12'hF11; #1 check("mvendorid", csr_rdata, 32'h7973_7978);
        csr_addr = 12'hF12; #1 check("marchid", csr_rdata, 32'h016F_6E86);
        csr_addr = 12'h123; #1 check("unmapped read", csr_rdata, 32'd0);

        // ALU directed
        alu_op = 4'h0; op_a = 32'd7;          op_b = 32'hFFFF_FFF8; #1 check("ADD 7+-8", alu_c, 32'hFFFF_FFFF);
        alu_op = 4'h4; op_a = 32'h8000_0000;  op_b = 32'd4;         #1 check("SRA", alu_c, 32'hF800_0000);
        alu_op = 4'h6; op_a = 32'd1;          op_b = 32'hFFFF_FFFF; #1 check("LTU", alu_c, 32'd1);
        alu_op = 4'h5; op_a = 32'd1;          op_b = 32'hFFFF_FFFF; #1 check("LT signed", alu_c, 32'd0);
        alu_op = 4'h2; op_a = 32'd1;          op_b = 32'd33;        #1 check("SLL shamt 5 bits", alu_c, 32'd2);
        alu_op = 4'hD; op_a = 32'hFFFF_FFFF;  op_b = 32'd0;         #1 check("GE -1 vs 0", alu_c, 32'd0);
        alu_op = 4'hB; op_a = 32'h1234_5678;  op_b = 32'h1234_5678; #1 check("EQ", alu_c, 32'd1);
        alu_op = 4'hF; op_a = 32'h1234_5678;  op_b = 32'h1;         #1 check("undefined op", alu_c, 32'd0);

        // ALU random against model
        for (int i = 0; i < 60; i++) begin
            alu_op = 4'($urandom_range(0, 15)); op_a = pick(); op_b = $urandom;
            #1 check($sformatf("ALU rand op%0d", alu_op), alu_c, alu_ref(alu_op, op_a, op_b));
        end

        // MDU directed
        run_mdu("MUL 3*-5",        3'd0, 32'd3,          32'hFFFF_FFFB, 32'hFFFF_FFF1);
        run_mdu("MULHU max^2",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mdu("MULH min^2",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run_mdu("MULHSU -1*umax",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mdu("DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_mdu("REM -7/2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_mdu("DIVU 5/0",        3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF);
        run_mdu("REMU 5/0",        3'd7, 32'd5,          32'd0,         32'd5);
        run_mdu("DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_mdu("REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        // Abort by dropping mdu_valid_i mid-BUSY
        @(negedge clock);
        mdu_op = 3'd4; op_a = 32'd100; op_b = 32'd7; mdu_valid_i = 1'b1;
        repeat (10) @(negedge clock);
        mdu_valid_i = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clock); if (mdu_valid_o) pulses++; end
        check("abort no pulse", 32'(pulses), 32'd0);
        run_mdu("DIVU after abort", 3'd5, 32'd100, 32'd7, 32'd14);

        // Reset mid-BUSY
        @(negedge clock);
        mdu_op = 3'd0; op_a = 32'd9; op_b = 32'd9; mdu_valid_i = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1; mdu_valid_i = 1'b0;
        @(negedge clock);
        reset = 1'b0; model_reset();
        pulses = 0;
        repeat (40) begin @(negedge clock); if (mdu_valid_o) pulses++; end
        check("reset mid-op no pulse", 32'(pulses), 32'd0);
        check("reset mid-op mdu_c", mdu_c, 32'd0);
        run_mdu("MUL after reset", 3'd0, 32'd9, 32'd9, 32'd81);

        // MDU random against model
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7)); ra = pick(); rb = pick();
            run_mdu($sformatf("MDU rand op%0d %h %h", rop, ra, rb), rop, ra, rb, mdu_ref(rop, ra, rb));
        end

        // CSR directed
        do_csr(12'h305, 2'd1, 32'h8000_0100);
        do_csr(12'h305, 2'd2, 32'h0000_0003);
        csr_addr = 12'h305; #1 check("mtvec RW+RS", csr_rdata, 32'h8000_0103);
        do_csr(12'h300, 2'd3, 32'h0000_0800);
        csr_addr = 12'h300; #1 check("mstatus RC", csr_rdata, 32'h0000_1000);
        do_csr(12'hF11, 2'd1, 32'h0);
        csr_addr = 12'hF11; #1 check("mvendorid RO", csr_rdata, 32'h7973_7978);
        do_csr(12'h123, 2'd1, 32'hDEAD_BEEF);
        csr_addr = 12'h123; #1 check("unmapped write ignored", csr_rdata, 32'd0);
        @(negedge clock);
        csr_addr = 12'h341; csr_op = 2'd1; csr_wdata = 32'hFFFF_FFFF; issue = 1'b0;
        @(negedge clock);
        csr_op = 2'd0;
        #1 check("no write without issue", csr_rdata, 32'd0);

        // ecall with a competing CSR write, then mret
        @(negedge clock);
        pc = 32'h8000_0010; ecall = 1'b1; issue = 1'b1;
        csr_addr = 12'h305; csr_op = 2'd1; csr_wdata = 32'hDEAD_0000;
        #1 check("ecall rdata=mtvec", csr_rdata, 32'h8000_0103);
        @(negedge clock);
        ecall = 1'b0; issue = 1'b0; csr_op = 2'd0;
        m_mepc = 32'h8000_0010; m_mcause = 32'd11;
        csr_addr = 12'h341; #1 check("ecall mepc", csr_rdata, 32'h8000_0010);
        csr_addr = 12'h342; #1 check("ecall mcause", csr_rdata, 32'd11);
        csr_addr = 12'h305; #1 check("ecall beats csr write", csr_rdata, 32'h8000_0103);
        @(negedge clock);
        mret = 1'b1; issue = 1'b1; csr_addr = 12'h300;
        #1 check("mret rdata=mepc", csr_rdata, 32'h8000_0010);
        @(negedge clock);
        mret = 1'b0; issue = 1'b0;
        #1 check("mret no side effect", csr_rdata, 32'h0000_1000);

        // CSR random against model
        for (int i = 0; i < 24; i++) begin
            logic [11:0] wa;
            wa = addrs[$urandom_range(0, 6)];
            do_csr(wa, 2'($urandom_range(0, 3)), $urandom);
            check_csr($sformatf("CSR rand %h", wa), wa);
            check_csr("CSR rand other", addrs[$urandom_range(0, 6)]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
